// File: rtl/ex.sv
// Execute stage: combinational ALU result path, HI/LO register pair and a
// 32-iteration restoring divider that holds the pipeline while it runs.
module ex (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stall_req_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h7C;
    localparam logic [7:0] OP_SRL  = 8'h02;
    localparam logic [7:0] OP_SRA  = 8'h03;
    localparam logic [7:0] OP_ADDU = 8'h21;
    localparam logic [7:0] OP_SUBU = 8'h23;
    localparam logic [7:0] OP_SLT  = 8'h2A;
    localparam logic [7:0] OP_DIV  = 8'h1A;
    localparam logic [7:0] OP_DIVU = 8'h1B;
    localparam logic [7:0] OP_MFHI = 8'h10;
    localparam logic [7:0] OP_MFLO = 8'h12;

    localparam logic [2:0] SEL_LOGIC = 3'd1;
    localparam logic [2:0] SEL_SHIFT = 3'd2;
    localparam logic [2:0] SEL_MOVE  = 3'd3;
    localparam logic [2:0] SEL_ARITH = 3'd4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DBZ  = 2'd1;
    localparam logic [1:0] S_ON   = 2'd2;
    localparam logic [1:0] S_END  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] rem_q, rem_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        is_div;
    logic        is_sdiv;
    logic [32:0] partial;
    logic [32:0] diff;
    logic [31:0] result;

    assign is_div  = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    assign is_sdiv = (aluop_i == OP_DIV);

    // dvd_q shifts dividend bits out at the top while quotient bits enter at the bottom
    assign partial = {rem_q, dvd_q[31]};
    assign diff    = partial - {1'b0, dvs_q};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        case (state_q)
            S_IDLE: begin
                if (is_div) begin
                    state_d    = (reg2_i == 32'd0) ? S_DBZ : S_ON;
                    cnt_d      = 5'd0;
                    rem_d      = 32'd0;
                    dvd_d      = (is_sdiv && reg1_i[31]) ? (32'd0 - reg1_i) : reg1_i;
                    dvs_d      = (is_sdiv && reg2_i[31]) ? (32'd0 - reg2_i) : reg2_i;
                    neg_quot_d = is_sdiv && (reg1_i[31] ^ reg2_i[31]);
                    neg_rem_d  = is_sdiv && reg1_i[31];
                end
            end
            S_DBZ: begin
                state_d = S_END;
                dvd_d   = 32'd0;
                rem_d   = 32'd0;
            end
            S_ON: begin
                if (!diff[32]) begin
                    rem_d = diff[31:0];
                    dvd_d = {dvd_q[30:0], 1'b1};
                end else begin
                    rem_d = partial[31:0];
                    dvd_d = {dvd_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = S_END;
            end
            default: begin
                lo_d    = neg_quot_q ? (32'd0 - dvd_q) : dvd_q;
                hi_d    = neg_rem_q ? (32'd0 - rem_q) : rem_q;
                state_d = S_IDLE;
            end
        endcase
        if (flush) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            dvd_q      <= 32'd0;
            dvs_q      <= 32'd0;
            rem_q      <= 32'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    always_comb begin
        result = 32'd0;
        case (alusel_i)
            SEL_LOGIC: begin
                case (aluop_i)
                    OP_OR:   result = reg1_i | reg2_i;
                    OP_AND:  result = reg1_i & reg2_i;
                    OP_XOR:  result = reg1_i ^ reg2_i;
                    OP_NOR:  result = ~(reg1_i | reg2_i);
                    default: result = 32'd0;
                endcase
            end
            SEL_SHIFT: begin
                case (aluop_i)
                    OP_SLL:  result = reg1_i << reg2_i[4:0];
                    OP_SRL:  result = reg1_i >> reg2_i[4:0];
                    OP_SRA:  result = $signed(reg1_i) >>> reg2_i[4:0];
                    default: result = 32'd0;
                endcase
            end
            SEL_MOVE: begin
                case (aluop_i)
                    OP_MFHI: result = hi_q;
                    OP_MFLO: result = lo_q;
                    default: result = 32'd0;
                endcase
            end
            SEL_ARITH: begin
                case (aluop_i)
                    OP_ADDU: result = reg1_i + reg2_i;
                    OP_SUBU: result = reg1_i - reg2_i;
                    OP_SLT:  result = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
                    default: result = 32'd0;
                endcase
            end
            default: result = 32'd0;
        endcase
    end

    assign wd_o        = rst ? 5'd0 : wd_i;
    assign wreg_o      = rst ? 1'b0 : (wreg_i && !is_div);
    assign wdata_o     = rst ? 32'd0 : result;
    assign stall_req_o = !rst && is_div && (state_q != S_END);
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;
endmodule
